// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin arbiter/sequencer that shares one sequential
//            unsigned WxW multiplier among N requesters. The winner's
//            operands are latched, the multiplier is started, and the
//            2W-bit product is returned with a one-cycle done pulse. If the
//            multiplier never answers, the operation is aborted after
//            TIMEOUT cycles and done is accompanied by err.
// Ports    : clk, rst_n         - clock, async active-low reset
//            i_req[N]           - request levels (held until own done)
//            i_a_in / i_b_in    - flat operand buses, slice i at [i*W +: W]
//            o_gnt[N]           - one-hot grant, START through DONE
//            o_done[N]          - one-cycle completion pulse to the owner
//            o_result[2W]       - product of the last completed operation
//            o_err              - timeout flag, coincident with done
//            o_busy             - FSM not idle
//            o_mul_start        - one-cycle multiplier start
//            o_mul_a / o_mul_b  - latched multiplier operands
//            i_mul_result[2W]   - multiplier product
//            i_mul_ready        - multiplier ready level
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic [N*W-1:0]   i_a_in,
  input  logic [N*W-1:0]   i_b_in,
  output logic [N-1:0]     o_gnt,
  output logic [N-1:0]     o_done,
  output logic [2*W-1:0]   o_result,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_mul_start,
  output logic [W-1:0]     o_mul_a,
  output logic [W-1:0]     o_mul_b,
  input  logic [2*W-1:0]   i_mul_result,
  input  logic             i_mul_ready
);

  localparam int c_ptr_w = (N > 1) ? $clog2(N) : 1;
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_ptr_w-1:0] c_last_idx = c_ptr_w'(N - 1);
  localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_ptr_w-1:0]   r_rr;
  logic [c_ptr_w-1:0]   r_owner;
  logic [W-1:0]         r_mul_a;
  logic [W-1:0]         r_mul_b;
  logic [2*W-1:0]       r_result;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_timed_out;

  logic [W-1:0]         w_a [N];
  logic [W-1:0]         w_b [N];
  logic                 w_win_found;
  logic [c_ptr_w-1:0]   w_win_idx;
  logic [c_ptr_w-1:0]   w_scan;
  int                   w_pos;
  logic [N-1:0]         w_owner_oh;
  logic [c_ptr_w-1:0]   w_rr_nxt;

  // Unpack the flat operand buses so the winner index selects directly.
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_a[g] = i_a_in[g*W +: W];
    assign w_b[g] = i_b_in[g*W +: W];
  end

  // Round-robin scan: first set request at or above r_rr, wrapping.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_pos       = 0;
    w_scan      = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(r_rr) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_scan = w_pos[c_ptr_w-1:0];
      if (!w_win_found && i_req[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
    end
  end

  assign w_owner_oh = N'(1) << r_owner;
  assign w_rr_nxt   = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_win_found) w_state_nxt = S_START;
      S_START:  w_state_nxt = S_SETTLE;
      // Ready is deliberately not looked at here: it may still be the
      // leftover level from the previous operation.
      S_SETTLE: w_state_nxt = S_WAIT;
      S_WAIT:   if (i_mul_ready || (r_cnt == c_to_last)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_owner     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_owner     <= w_win_idx;
            r_mul_a     <= w_a[w_win_idx];
            r_mul_b     <= w_b[w_win_idx];
            r_timed_out <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A ready in the final timeout cycle still counts as success.
          if (i_mul_ready) begin
            r_result <= i_mul_result;
          end else if (r_cnt == c_to_last) begin
            r_timed_out <= 1'b1;
          end
        end
        S_DONE: begin
          r_rr  <= w_rr_nxt;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; no path from i_req.
  assign o_busy      = (r_state != S_IDLE);
  assign o_gnt       = o_busy ? w_owner_oh : '0;
  assign o_mul_start = (r_state == S_START);
  assign o_done      = (r_state == S_DONE) ? w_owner_oh : '0;
  assign o_err       = (r_state == S_DONE) && r_timed_out;
  assign o_result    = r_result;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arbiter
// Purpose  : Self-checking bench for mul_share_arbiter with a behavioural
//            sequential multiplier (latency L), a cycle model of the
//            arbitration rules and directed scenarios with literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 32;
  localparam int L       = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   a_in = '0;
  logic [N*W-1:0]   b_in = '0;
  logic [N-1:0]     o_gnt;
  logic [N-1:0]     o_done;
  logic [2*W-1:0]   o_result;
  logic             o_err;
  logic             o_busy;
  logic             o_mul_start;
  logic [W-1:0]     o_mul_a;
  logic [W-1:0]     o_mul_b;
  logic [2*W-1:0]   mul_result = '0;
  logic             mul_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_start = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_a_in(a_in), .i_b_in(b_in),
    .o_gnt(o_gnt), .o_done(o_done), .o_result(o_result), .o_err(o_err),
    .o_busy(o_busy), .o_mul_start(o_mul_start), .o_mul_a(o_mul_a),
    .o_mul_b(o_mul_b), .i_mul_result(mul_result), .i_mul_ready(mul_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: ready drops on start, rises L edges later.
  bit             mode_stale = 1'b0;
  bit             mode_dead  = 1'b0;
  int             mb_cnt = 0;
  bit             mb_run = 1'b0;
  bit             mb_drop = 1'b0;
  logic [2*W-1:0] mb_prod = '0;

  always @(posedge clk) begin
    if (o_mul_start) begin
      mb_cnt  <= L;
      mb_run  <= 1'b1;
      mb_prod <= o_mul_a * o_mul_b;
      mb_drop <= mode_stale;
      if (!mode_stale) mul_ready <= 1'b0;
    end else begin
      if (mb_drop) begin
        mul_ready <= 1'b0;
        mb_drop   <= 1'b0;
      end
      if (mb_run) begin
        if (mb_cnt == 1) begin
          mb_run <= 1'b0;
          if (!mode_dead) begin
            mul_ready  <= 1'b1;
            mul_result <= mb_prod;
          end
        end
        mb_cnt <= mb_cnt - 1;
      end
    end
  end

  // Reference model of the arbitration rules.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  bit             m_active = 0, m_fin = 0, m_err = 0;
  int             m_ph = 0, m_wcnt = 0, m_owner = 0, m_rr = 0;
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [2*W-1:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_fin <= 0; m_err <= 0; m_ph <= 0; m_wcnt <= 0;
      m_owner <= 0; m_rr <= 0; m_a <= '0; m_b <= '0; m_res <= '0;
    end else if (!m_active) begin
      if (req != '0) begin
        m_active <= 1; m_ph <= 0; m_wcnt <= 0; m_err <= 0;
        m_owner  <= pick(req, m_rr);
        m_a      <= a_in[pick(req, m_rr)*W +: W];
        m_b      <= b_in[pick(req, m_rr)*W +: W];
      end
    end else if (m_fin) begin
      m_active <= 0; m_fin <= 0; m_err <= 0;
      m_rr     <= (m_owner + 1) % N;
    end else if (m_ph < 2) begin
      m_ph <= m_ph + 1;
    end else begin
      if (mul_ready) begin
        m_res <= m_a * m_b;
        m_fin <= 1;
      end else if (m_wcnt == TIMEOUT - 1) begin
        m_err <= 1;
        m_fin <= 1;
      end
      m_wcnt <= m_wcnt + 1;
    end
  end

  // Per-cycle comparison against the model.
  logic [N-1:0] one = 1;
  logic [N-1:0] e_gnt, e_done;
  always @(negedge clk) begin
    e_gnt  = m_active ? (one << m_owner) : '0;
    e_done = (m_active && m_fin) ? (one << m_owner) : '0;
    n_tests++;
    if (o_gnt !== e_gnt || o_done !== e_done || o_busy !== m_active ||
        o_err !== (m_fin && m_err) ||
        o_mul_start !== (m_active && !m_fin && m_ph == 0) ||
        o_result !== m_res || o_mul_a !== m_a || o_mul_b !== m_b) begin
      n_fail++;
      $display("FAIL cycle %0d model: gnt=%b/%b done=%b/%b busy=%b/%b err=%b/%b start=%b/%b res=%h/%h a=%h/%h b=%h/%h (got/exp)",
               cyc, o_gnt, e_gnt, o_done, e_done, o_busy, m_active, o_err, m_fin && m_err,
               o_mul_start, (m_active && !m_fin && m_ph == 0), o_result, m_res,
               o_mul_a, m_a, o_mul_b, m_b);
    end
    if (o_mul_start) n_start++;
    if (o_done != '0) n_done++;
  end

  // Helpers.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_done(output int owner, output bit ok);
    ok = 0;
    owner = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_done != '0) begin
        ok = 1;
        owner = oh_idx(o_done);
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: no done within bound, got none expected pulse");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  int             own;
  bit             ok;
  int             t0, s0, d0;
  int             seq [4];
  logic [2*W-1:0] res [4];

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_gnt",  32'(o_gnt), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_res",  32'(o_result), 0);
    chk("reset_mula", 32'(o_mul_a), 0);
    #2 rst_n = 1'b1;

    // Single requester, latency 13.
    @(negedge clk);
    set_op(0, 8'h0F, 8'h11);
    s0 = n_start;
    req = 4'b0001;
    t0 = cyc;
    wait_done(own, ok);
    req = '0;
    chk("single_latency", 32'(cyc - t0), 13);
    chk("single_done",    32'(o_done), 32'h1);
    chk("single_result",  32'(o_result), 32'h00FF);
    chk("single_err",     32'(o_err), 0);
    chk("single_starts",  32'(n_start - s0), 1);

    // Four simultaneous requesters after reset.
    do_reset();
    set_op(0, 8'd3, 8'd5);
    set_op(1, 8'hFF, 8'hFF);
    set_op(2, 8'h00, 8'h7A);
    set_op(3, 8'h80, 8'h02);
    s0 = n_start;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_done(own, ok);
      seq[k] = own;
      res[k] = o_result;
      chk("all4_onehot", 32'($countones(o_done)), 1);
      if (own >= 0) req[own] = 1'b0;
    end
    chk("all4_order0", 32'(seq[0]), 0);
    chk("all4_order1", 32'(seq[1]), 1);
    chk("all4_order2", 32'(seq[2]), 2);
    chk("all4_order3", 32'(seq[3]), 3);
    chk("all4_res0", 32'(res[0]), 32'h000F);
    chk("all4_res1", 32'(res[1]), 32'hFE01);
    chk("all4_res2", 32'(res[2]), 32'h0000);
    chk("all4_res3", 32'(res[3]), 32'h0100);
    chk("all4_starts", 32'(n_start - s0), 4);

    // Fairness: req[1] held, req[2] joins during its operation.
    @(negedge clk);
    set_op(1, 8'd2, 8'd3);
    set_op(2, 8'd4, 8'd4);
    req[1] = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (o_gnt[1]) ok = 1;
    end
    chk("fair_gnt1_seen", 32'(ok), 1);
    req[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(own, ok);
      seq[k] = own;
      res[k] = o_result;
      if (own == 2) req[2] = 1'b0;
      if (k == 2) req = '0;
    end
    chk("fair_seq0", 32'(seq[0]), 1);
    chk("fair_seq1", 32'(seq[1]), 2);
    chk("fair_seq2", 32'(seq[2]), 1);
    chk("fair_res1", 32'(res[1]), 32'h0010);

    // Stale ready from previous operation must not complete this one.
    @(negedge clk);
    mode_stale = 1'b1;
    set_op(3, 8'd7, 8'd9);
    req[3] = 1'b1;
    wait_done(own, ok);
    req = '0;
    chk("stale_owner",  32'(own), 3);
    chk("stale_result", 32'(o_result), 32'h003F);
    @(negedge clk);
    mode_stale = 1'b0;

    // Timeout: multiplier never answers.
    mode_dead = 1'b1;
    set_op(2, 8'd3, 8'd3);
    req[2] = 1'b1;
    wait_done(own, ok);
    req = '0;
    chk("to_owner",  32'(own), 2);
    chk("to_err",    32'(o_err), 1);
    chk("to_result", 32'(o_result), 32'h003F);
    @(negedge clk);
    chk("to_err_pulse", 32'(o_err), 0);
    mode_dead = 1'b0;
    set_op(2, 8'd4, 8'd5);
    req[2] = 1'b1;
    wait_done(own, ok);
    req = '0;
    chk("after_to_result", 32'(o_result), 32'h0014);
    chk("after_to_err",    32'(o_err), 0);

    // Reset in the middle of WAIT.
    @(negedge clk);
    set_op(0, 8'h10, 8'h10);
    req[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_busy_before", 32'(o_busy), 1);
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt",   32'(o_gnt), 0);
    chk("midrst_busy",  32'(o_busy), 0);
    chk("midrst_start", 32'(o_mul_start), 0);
    chk("midrst_res",   32'(o_result), 0);
    chk("midrst_mula",  32'(o_mul_a), 0);
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 32'(n_done - d0), 0);
    set_op(1, 8'h0C, 8'h0D);
    req[1] = 1'b1;
    wait_done(own, ok);
    req = '0;
    chk("midrst_owner",  32'(own), 1);
    chk("midrst_result", 32'(o_result), 32'h009C);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
